// File: rtl/axi_helper.sv
// Shared AXI helper package.
// Holds the channel payload widths, the channel FIFO latency mode, the default
// FIFO depth, and a power-of-two helper used for parameter checking.
package axi_helper;

  // Width of one R beat: 64-bit data, 2-bit response.
  localparam int unsigned RxDATA_W = 66;

  // Default number of entries in a channel FIFO.
  localparam int unsigned FIFO_DEPTH_DFLT = 4;

  // FIFO_REG: one-cycle in-to-out latency. FIFO_BYPASS: zero latency when empty.
  typedef enum logic {
    FIFO_REG    = 1'b0,
    FIFO_BYPASS = 1'b1
  } fifo_mode_t;

  // True when v is a power of two and at least 2.
  function automatic bit is_pow2(input int unsigned v);
    return (v >= 32'd2) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/axi_chan_fifo_mem.sv
// Storage array for axi_chan_fifo.
// DEPTH x WIDTH entries, synchronous write, asynchronous read.
// Ports:
//   clk      clock
//   we_i     write enable
//   waddr_i  write address (pointer LSBs)
//   wdata_i  write data
//   raddr_i  read address (pointer LSBs)
//   rdata_o  read data, combinational from raddr_i
module axi_chan_fifo_mem #(
  parameter int unsigned WIDTH = 66,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi_chan_fifo.sv
// Valid/ready channel buffer with DEPTH entries.
// Sits on one AXI channel between interconnect and slave logic.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   flush        synchronous clear of all stored beats
//   s_valid/s_ready/s_data   upstream handshake and payload
//   m_valid/m_ready/m_data   downstream handshake and payload
//   count        stored beats (a bypassed beat is never counted)
//   almost_full  count >= AF_LEVEL
module axi_chan_fifo
  import axi_helper::*;
#(
  parameter int unsigned WIDTH    = 66,
  parameter int unsigned DEPTH    = FIFO_DEPTH_DFLT,
  parameter fifo_mode_t  MODE     = FIFO_REG,
  parameter int unsigned AF_LEVEL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [WIDTH-1:0]           s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [WIDTH-1:0]           m_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  if (!is_pow2(DEPTH) || (AF_LEVEL < 32'd1) || (AF_LEVEL > DEPTH)) begin : g_bad_param
    $error("axi_chan_fifo: DEPTH must be a power of two >= 2 and AF_LEVEL in 1..DEPTH");
  end

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_s, empty_s, bypass_s;
  logic             push_s, wr_en_s, rd_adv_s;
  logic [WIDTH-1:0] rdata_s;

  // One extra pointer bit distinguishes full from empty when the LSBs match.
  assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_s = (wr_ptr_q == rd_ptr_q);

  // Ready never looks at m_ready, so a full FIFO refuses a beat even if it pops.
  assign s_ready = !full_s && !rst && !flush;
  assign push_s  = s_valid && s_ready;

  // Bypass path is live only when nothing is stored.
  assign bypass_s = (MODE == FIFO_BYPASS) && empty_s;

  // Output selection: stored head, or the incoming beat on the bypass path.
  always_comb begin
    m_valid = 1'b0;
    m_data  = rdata_s;
    if (rst || flush) begin
      m_valid = 1'b0;
    end else if (bypass_s) begin
      m_valid = push_s;
      m_data  = s_data;
    end else begin
      m_valid = !empty_s;
    end
  end

  // A bypassed beat taken downstream the same cycle never touches storage.
  assign wr_en_s  = push_s && !(bypass_s && m_ready);
  assign rd_adv_s = m_valid && m_ready && !bypass_s;

  // Next-state for pointers and occupancy; flush clears, push/pop otherwise.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_adv_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_en_s, rd_adv_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count       = count_q;
  assign almost_full = (count_q >= CW'(AF_LEVEL));

  axi_chan_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_en_s),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (s_data),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rdata_s)
  );

endmodule

// File: tb/tb_axi_chan_fifo.sv
// Self-checking bench for axi_chan_fifo: one registered and one bypass instance.
module tb_axi_chan_fifo;
  import axi_helper::*;

  logic        clk;
  logic        rst;
  // Registered-mode instance signals.
  logic        a_fl, a_sv, a_sr, a_mv, a_mr, a_af;
  logic [65:0] a_sd, a_md;
  logic [2:0]  a_cnt;
  // Bypass-mode instance signals.
  logic        b_fl, b_sv, b_sr, b_mv, b_mr, b_af;
  logic [65:0] b_sd, b_md;
  logic [2:0]  b_cnt;

  int n_checks;
  int n_err;

  axi_chan_fifo #(.WIDTH(66), .DEPTH(4), .MODE(FIFO_REG), .AF_LEVEL(3)) dut_reg (
    .clk(clk), .rst(rst), .flush(a_fl),
    .s_valid(a_sv), .s_ready(a_sr), .s_data(a_sd),
    .m_valid(a_mv), .m_ready(a_mr), .m_data(a_md),
    .count(a_cnt), .almost_full(a_af)
  );

  axi_chan_fifo #(.WIDTH(66), .DEPTH(4), .MODE(FIFO_BYPASS), .AF_LEVEL(3)) dut_byp (
    .clk(clk), .rst(rst), .flush(b_fl),
    .s_valid(b_sv), .s_ready(b_sr), .s_data(b_sd),
    .m_valid(b_mv), .m_ready(b_mr), .m_data(b_md),
    .count(b_cnt), .almost_full(b_af)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        sv;
    logic [65:0] sd;
    logic        mr;
    logic        sr;
    logic        mv;
    logic        dchk;
    logic [65:0] md;
    logic [2:0]  cnt;
    logic        af;
  } vec_t;

  vec_t        vecs[10];
  logic [65:0] sb_q[$];
  logic [65:0] exp_d;

  // Push n beats into the registered instance with m_ready low.
  task automatic push_a(input int n, input int base);
    for (int k = 0; k < n; k++) begin
      a_sv = 1'b1; a_sd = 66'(base + k); a_mr = 1'b0;
      @(negedge clk);
    end
    a_sv = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_err = 0;
    rst = 1'b1;
    a_fl = 1'b0; a_sv = 1'b0; a_sd = 66'd0; a_mr = 1'b0;
    b_fl = 1'b0; b_sv = 1'b0; b_sd = 66'd0; b_mr = 1'b0;

    // Reset state.
    @(negedge clk); #1;
    chk("rst_s_ready", 66'(a_sr), 66'd0);
    chk("rst_m_valid", 66'(a_mv), 66'd0);
    chk("rst_count", 66'(a_cnt), 66'd0);
    chk("rst_af", 66'(a_af), 66'd0);
    @(negedge clk);
    rst = 1'b0; #1;
    chk("post_rst_s_ready", 66'(a_sr), 66'd1);
    chk("post_rst_count", 66'(a_cnt), 66'd0);
    chk("post_rst_m_valid", 66'(a_mv), 66'd0);
    @(negedge clk);

    // Fill/drain vectors: outputs observed before the edge with these inputs.
    vecs[0] = '{1'b1, 66'h1, 1'b0, 1'b1, 1'b0, 1'b0, 66'h0, 3'd0, 1'b0};
    vecs[1] = '{1'b1, 66'h2, 1'b0, 1'b1, 1'b1, 1'b1, 66'h1, 3'd1, 1'b0};
    vecs[2] = '{1'b1, 66'h3, 1'b0, 1'b1, 1'b1, 1'b1, 66'h1, 3'd2, 1'b0};
    vecs[3] = '{1'b1, 66'h4, 1'b0, 1'b1, 1'b1, 1'b1, 66'h1, 3'd3, 1'b1};
    vecs[4] = '{1'b0, 66'h0, 1'b0, 1'b0, 1'b1, 1'b1, 66'h1, 3'd4, 1'b1};
    vecs[5] = '{1'b0, 66'h0, 1'b1, 1'b0, 1'b1, 1'b1, 66'h1, 3'd4, 1'b1};
    vecs[6] = '{1'b0, 66'h0, 1'b1, 1'b1, 1'b1, 1'b1, 66'h2, 3'd3, 1'b1};
    vecs[7] = '{1'b0, 66'h0, 1'b1, 1'b1, 1'b1, 1'b1, 66'h3, 3'd2, 1'b0};
    vecs[8] = '{1'b0, 66'h0, 1'b1, 1'b1, 1'b1, 1'b1, 66'h4, 3'd1, 1'b0};
    vecs[9] = '{1'b0, 66'h0, 1'b1, 1'b1, 1'b0, 1'b0, 66'h0, 3'd0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      a_sv = vecs[i].sv; a_sd = vecs[i].sd; a_mr = vecs[i].mr;
      #1;
      chk($sformatf("fd%0d_s_ready", i), 66'(a_sr), 66'(vecs[i].sr));
      chk($sformatf("fd%0d_m_valid", i), 66'(a_mv), 66'(vecs[i].mv));
      if (vecs[i].dchk) chk($sformatf("fd%0d_m_data", i), a_md, vecs[i].md);
      chk($sformatf("fd%0d_count", i), 66'(a_cnt), 66'(vecs[i].cnt));
      chk($sformatf("fd%0d_af", i), 66'(a_af), 66'(vecs[i].af));
      @(negedge clk);
    end
    a_sv = 1'b0; a_mr = 1'b0;

    // Wrap-around stream through the scoreboard.
    begin
      int sent, got, cyc;
      logic acc;
      sent = 0; got = 0; cyc = 0;
      while (got < 20 && cyc < 200) begin
        a_sv = (sent < 20);
        a_sd = 66'(32'h100 + sent);
        a_mr = cyc[0] ? 1'b0 : 1'b1;
        #1;
        acc = a_sv && a_sr;
        if (acc) sb_q.push_back(a_sd);
        if (a_mv && a_mr) begin
          if (sb_q.size() == 0) begin
            chk("wrap_unexpected_beat", a_md, 66'h0);
          end else begin
            exp_d = sb_q.pop_front();
            chk($sformatf("wrap_beat%0d", got), a_md, exp_d);
          end
          got++;
        end
        @(negedge clk);
        if (acc) sent++;
        cyc++;
      end
      a_sv = 1'b0; a_mr = 1'b0;
      chk("wrap_all_received", 66'(got), 66'd20);
      #1;
      chk("wrap_empty_after", 66'(a_mv), 66'd0);
      chk("wrap_count_after", 66'(a_cnt), 66'd0);
      @(negedge clk);
    end

    // Bypass: empty, downstream ready -> same-cycle pass-through.
    b_sv = 1'b1; b_sd = 66'h2A; b_mr = 1'b1; #1;
    chk("byp_mv", 66'(b_mv), 66'd1);
    chk("byp_md", b_md, 66'h2A);
    chk("byp_cnt", 66'(b_cnt), 66'd0);
    @(negedge clk);
    b_sv = 1'b0; #1;
    chk("byp_cnt_after", 66'(b_cnt), 66'd0);
    chk("byp_mv_after", 66'(b_mv), 66'd0);
    @(negedge clk);
    // Bypass: empty, downstream stalled -> stored and held.
    b_sv = 1'b1; b_sd = 66'h2A; b_mr = 1'b0; #1;
    chk("bypst_mv", 66'(b_mv), 66'd1);
    chk("bypst_md", b_md, 66'h2A);
    @(negedge clk);
    b_sv = 1'b0; b_sd = 66'h3FF; #1;
    chk("bypst_cnt1", 66'(b_cnt), 66'd1);
    chk("bypst_mv1", 66'(b_mv), 66'd1);
    chk("bypst_md1", b_md, 66'h2A);
    @(negedge clk); #1;
    chk("bypst_md_hold", b_md, 66'h2A);
    b_mr = 1'b1; #1;
    chk("bypst_md_pop", b_md, 66'h2A);
    @(negedge clk);
    b_mr = 1'b0; #1;
    chk("bypst_cnt_end", 66'(b_cnt), 66'd0);
    chk("bypst_mv_end", 66'(b_mv), 66'd0);
    @(negedge clk);

    // Full with simultaneous pop: push refused that cycle, accepted next.
    push_a(4, 32'h10);
    a_sv = 1'b1; a_sd = 66'h14; a_mr = 1'b1; #1;
    chk("fullpop_s_ready", 66'(a_sr), 66'd0);
    chk("fullpop_cnt", 66'(a_cnt), 66'd4);
    chk("fullpop_md", a_md, 66'h10);
    @(negedge clk);
    a_mr = 1'b0; #1;
    chk("fullpop_cnt3", 66'(a_cnt), 66'd3);
    chk("fullpop_s_ready1", 66'(a_sr), 66'd1);
    @(negedge clk);
    a_sv = 1'b0; #1;
    chk("fullpop_cnt4", 66'(a_cnt), 66'd4);
    for (int k = 0; k < 4; k++) begin
      a_mr = 1'b1; #1;
      chk($sformatf("fullpop_drain%0d", k), a_md, 66'(32'h11 + k));
      @(negedge clk);
    end
    a_mr = 1'b0; #1;
    chk("fullpop_cnt_end", 66'(a_cnt), 66'd0);
    @(negedge clk);

    // Flush with three stored beats, competing push and pop.
    push_a(3, 32'h21);
    a_fl = 1'b1; a_sv = 1'b1; a_sd = 66'h99; a_mr = 1'b1; #1;
    chk("flush_s_ready", 66'(a_sr), 66'd0);
    chk("flush_m_valid", 66'(a_mv), 66'd0);
    @(negedge clk);
    a_fl = 1'b0; a_sv = 1'b0; a_mr = 1'b0; #1;
    chk("flush_cnt", 66'(a_cnt), 66'd0);
    chk("flush_mv_after", 66'(a_mv), 66'd0);
    chk("flush_sr_after", 66'(a_sr), 66'd1);
    @(negedge clk);

    // Reset mid-stream with two stored beats.
    push_a(2, 32'h31);
    rst = 1'b1; a_sv = 1'b1; a_sd = 66'h77; a_mr = 1'b1; #1;
    chk("mrst_m_valid", 66'(a_mv), 66'd0);
    chk("mrst_s_ready", 66'(a_sr), 66'd0);
    @(negedge clk);
    rst = 1'b0; a_sv = 1'b1; a_sd = 66'h55; a_mr = 1'b0; #1;
    chk("mrst_cnt", 66'(a_cnt), 66'd0);
    chk("mrst_mv_after", 66'(a_mv), 66'd0);
    chk("mrst_sr_after", 66'(a_sr), 66'd1);
    @(negedge clk);
    a_sv = 1'b0; #1;
    chk("mrst_first_mv", 66'(a_mv), 66'd1);
    chk("mrst_first_md", a_md, 66'h55);
    chk("mrst_cnt1", 66'(a_cnt), 66'd1);
    a_mr = 1'b1;
    @(negedge clk);
    a_mr = 1'b0; #1;
    chk("mrst_cnt_end", 66'(a_cnt), 66'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/axi_chan_fifo.md
Name: axi_chan_fifo

Overview:
Parametrised valid/ready channel buffer that generalises the single-stage channel slice to DEPTH entries.
- Selectable latency mode: registered, or empty-bypass.
- Exposes occupancy, an almost-full flag and a synchronous flush.
- Instantiated once per AXI channel (AW/W/B/AR/R) between interconnect and slave logic, with WIDTH set from the shared channel-width constants (e.g. WxDATA_W, RxDATA_W).

Parameters:
- WIDTH, 66: payload bits per beat (RxDATA_W for 64-bit data).
- DEPTH, 4: entries; power of two, ≥2.
- MODE, FIFO_REG: FIFO_REG = 1-cycle in→out latency; FIFO_BYPASS = zero latency when empty.
- AF_LEVEL, DEPTH-1: almost_full asserts when count ≥ AF_LEVEL; range 1..DEPTH.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all stored beats.
- s_valid  in  1  upstream beat valid.
- s_ready  out  1  upstream beat accepted when s_valid & s_ready.
- s_data  in  WIDTH  upstream payload.
- m_valid  out  1  downstream beat valid.
- m_ready  in  1  downstream accepts.
- m_data  out  WIDTH  downstream payload.
- count  out  $clog2(DEPTH+1)  stored beats (excludes bypassed beat).
- almost_full  out  1  count ≥ AF_LEVEL.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values while rst=1 and the cycle after:
  - pointers = 0, count = 0, almost_full = 0.
  - m_valid = 0, s_ready = 0 while rst is high.
  - s_ready = 1 from the first cycle rst is low.
  - Storage contents are not reset.
- Pointers: wr_ptr and rd_ptr are log2(DEPTH)+1 bits. They wrap modulo 2·DEPTH.
  - full = (MSBs differ & LSBs equal).
  - empty = (pointers equal).
- Ready rule: s_ready = !full & !rst & !flush. It is independent of m_ready, so there is no combinational ready path. No push is accepted when full, even if a pop happens in the same cycle.
- Push: s_valid & s_ready writes s_data to mem[wr_ptr] and increments wr_ptr (except the bypass case below).
- Pop: m_valid & m_ready increments rd_ptr.
- count updates:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
- FIFO_REG:
  - m_valid = !empty; m_data = mem[rd_ptr].
  - A beat accepted in cycle N appears on m_valid in cycle N+1.
  - Throughput is 1 beat/cycle at steady state.
- FIFO_BYPASS:
  - Non-empty: behaves exactly as FIFO_REG.
  - Empty: m_valid = s_valid & s_ready and m_data = s_data (combinational).
  - Empty, s_valid & m_ready: the beat passes through. Storage and count are untouched.
  - Empty, s_valid & !m_ready: the beat is written to storage. Next cycle m_valid = 1 with identical m_data.
- AXI stability: once m_valid = 1 it stays 1 and m_data stays stable until m_ready. This holds in both modes, provided upstream obeys the same rule.
- flush:
  - Takes priority over push and pop in the same cycle.
  - m_valid = 0 and s_ready = 0 during the flush cycle.
  - Next cycle: pointers equal, count = 0.
- Reset mid-operation: all beats are discarded, with the same values as at reset. No beat is emitted during the rst cycle.
- m_data while m_valid = 0 is unspecified; the bench must not check it.
- almost_full is combinational from registered count.
- Illegal parameters: DEPTH not a power of two, or AF_LEVEL out of range, are caught by an elaboration-time assertion.

Decomposition:
- Add to package axi_helper:
  - typedef enum logic {FIFO_REG, FIFO_BYPASS} fifo_mode_t.
  - localparam FIFO_DEPTH_DFLT = 4.
- Existing per-channel *_W widths and *_t structs remain the payload source. Users cast struct↔logic[WIDTH-1:0] at instantiation.
- Sub-module axi_chan_fifo_mem: DEPTH×WIDTH array with synchronous write and asynchronous read, addressed by the pointer LSBs. Pointer, count and handshake logic stay in the top module.

Test Plan:
- Fill/drain, FIFO_REG, DEPTH=4, AF_LEVEL=3:
  - Push 0x1,0x2,0x3,0x4 with m_ready=0 → count 1,2,3,4; almost_full rises with count=3; s_ready=0 after the 4th.
  - Then m_ready=1 → out 0x1..0x4 in order, one per cycle; count returns to 0.
- Wrap-around: stream 20 beats with an incrementing value, m_ready toggling 1,0,1,0 → all 20 arrive in order, none lost or duplicated; pointers wrap ≥4 times.
- Bypass, FIFO_BYPASS empty: s_valid=1, s_data=0x2A, m_ready=1 → m_valid=1, m_data=0x2A the same cycle; count stays 0. Repeat with m_ready=0 → count=1 next cycle, m_data=0x2A held until m_ready.
- Full with simultaneous pop, DEPTH=4 full, s_valid=1 and m_ready=1 → s_ready=0 that cycle; count goes 4→3; the incoming beat is accepted the following cycle.
- Flush with 3 stored beats, flush=1 together with s_valid=1, m_ready=1 → no transfer on either side that cycle; next cycle count=0, m_valid=0, s_ready=1.
- Reset mid-stream: rst=1 for 1 cycle with 2 beats stored → m_valid=0 and s_ready=0 during rst; count=0 after; the next pushed beat 0x55 is the first output.
